assert_obligation_tracker: RTL and testbench
============================================

ASSERT_OBLIGATION_TRACKER -- requirements
Module: assert_obligation_tracker

Interface
REQ-001 The module SHALL have parameter NUM_PROPS, default 2, meaning the number of independent single-step implication properties tracked.
REQ-002 The module SHALL have parameter CNT_W, default 16, meaning the width of every counter.
REQ-003 The module SHALL have parameter CYC_LIMIT, default 12, meaning the cycle count at which the run ends.
REQ-004 The module SHALL have parameter STOP_ON_FAIL, default 1, meaning a first failure ends the run immediately.
REQ-005 The module SHALL have port clk, input, 1 bit: the only clock; all logic is on its posedge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port start, input, 1 bit: a one-cycle pulse that begins a run.
REQ-008 The module SHALL have port antecedent, input, NUM_PROPS bits: bit i high means property i's antecedent matched this cycle.
REQ-009 The module SHALL have port consequent, input, NUM_PROPS bits: bit i is property i's consequent value this cycle.
REQ-010 The module SHALL have port pass_cnt, output, NUM_PROPS*CNT_W bits: per-property pass counts, with property i in slice i.
REQ-011 The module SHALL have port fail_cnt, output, NUM_PROPS*CNT_W bits: per-property fail counts, with the same slicing.
REQ-012 The module SHALL have port fail_pulse, output, NUM_PROPS bits: a one-cycle failure strobe per property.
REQ-013 The module SHALL have port first_fail_id, output, $clog2(NUM_PROPS) bits: the index of the first property to fail.
REQ-014 The module SHALL have port first_fail_cyc, output, CNT_W bits: the run cycle of the first failure.
REQ-015 The module SHALL have port state, output, 2 bits: the current FSM state.
REQ-016 The module SHALL have port done, output, 1 bit: level-high while in DONE or FAILED.
REQ-017 The module SHALL have port stop_req, output, 1 bit: a one-cycle pulse on entry to DONE or FAILED.

Function
REQ-018 The FSM SHALL have states IDLE=0, RUN=1, FAILED=2 and DONE=3.
REQ-019 The FSM SHALL move IDLE->RUN on start; in RUN, start SHALL be ignored.
REQ-020 In RUN, a cycle counter cyc SHALL start at 0 on the first RUN cycle and increment by 1 every RUN cycle.
REQ-021 In RUN, when antecedent[i]=1 at cycle t, pending[i] SHALL be set and the obligation SHALL be evaluated at cycle t+1 using consequent[i] (|=> semantics, latency 1).
REQ-022 At evaluation, consequent[i]=1 SHALL increment pass_cnt[i]; consequent[i]=0 SHALL increment fail_cnt[i] and SHALL assert fail_pulse[i] in the cycle after evaluation.
REQ-023 When antecedent[i] and a pending evaluation coincide in the same cycle, the old obligation SHALL be evaluated and the new one SHALL be registered, so back-to-back attempts are never lost (overlapping attempts).
REQ-024 Counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-025 The first failure of a run SHALL latch first_fail_id and first_fail_cyc, where first_fail_cyc is the cyc value at evaluation; if several properties fail in the same cycle, the lowest index SHALL win; later failures SHALL NOT change the latch.
REQ-026 With STOP_ON_FAIL=1, the first failure SHALL cause RUN->FAILED in the next cycle.
REQ-027 RUN->DONE SHALL occur when cyc==CYC_LIMIT and no failure-stop applies; a failure in that same cycle with STOP_ON_FAIL=1 SHALL take priority and select FAILED.
REQ-028 On leaving RUN, pending bits SHALL be discarded without being evaluated.
REQ-029 DONE and FAILED SHALL return to IDLE on start; that start SHALL clear all counters, pending bits and latches, and then enter RUN on the next cycle.
REQ-030 In IDLE, DONE and FAILED, antecedent and consequent SHALL be ignored.

Reset
REQ-031 While rst_n=0, the block SHALL asynchronously set: state=IDLE; cyc, pending, pass_cnt, fail_cnt, first_fail_id and first_fail_cyc to 0; fail_pulse=0; done=0; stop_req=0.
REQ-032 Reset asserted in the middle of a run SHALL abort the run immediately with no stop_req pulse.
REQ-033 Reset release SHALL take effect at the first posedge clk after rst_n rises.

Structure
REQ-034 The state enum and the default values for CNT_W and CYC_LIMIT SHALL live in the shared package assert_tb_pkg.
REQ-035 The per-property pending/evaluate/saturating-count logic SHALL be one sub-module, obligation_slot, instantiated NUM_PROPS times.

Verification
REQ-036 The bench SHALL check: start, then antecedent[0]=1 at cyc 0 and consequent[0]=1 at cyc 1 -> pass_cnt[0]=1, fail_cnt[0]=0, no fail_pulse.
REQ-037 The bench SHALL check: antecedent[1]=1 at cyc 3 and consequent[1]=0 at cyc 4 -> fail_pulse[1] one cycle, first_fail_id=1, first_fail_cyc=4, state=FAILED, stop_req one pulse.
REQ-038 The bench SHALL check: STOP_ON_FAIL=0 with an alternating pattern like the toggle stimulus -> run reaches cyc 12, state=DONE, counts match the model exactly.
REQ-039 The bench SHALL check: antecedent[0] held high for 5 cycles with consequent[0]=1 -> pass_cnt[0]=5 (overlap handled).
REQ-040 The bench SHALL check: both properties fail in the same cycle -> first_fail_id=0.
REQ-041 The bench SHALL check: rst_n=0 at cyc 6 mid-run -> all outputs 0 and state=IDLE immediately, no stop_req; CNT_W=3 with 9 passes -> pass_cnt=7.

Source files
------------

// File: rtl/assert_tb_pkg.sv
// Shared definitions for the obligation tracker: FSM state encoding and
// default widths/limits used by the tracker and its per-property slots.
package assert_tb_pkg;

    // Run controller states; the encoding is visible on the state port.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FAILED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int DEF_NUM_PROPS = 2;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_CYC_LIMIT = 12;

    // Larger of two integers, for sizing registers at elaboration time.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/assert_obligation_tracker_slot.sv
// One single-step implication (a |=> c) tracker: holds the pending
// obligation, evaluates it one cycle later and keeps saturating pass/fail
// counts plus a registered failure strobe.
module obligation_slot
    import assert_tb_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,       // wipe counts and pending bit
    input  logic             i_active,      // controller is in RUN
    input  logic             i_flush,       // last RUN cycle: drop new obligation
    input  logic             i_antecedent,
    input  logic             i_consequent,
    output logic [CNT_W-1:0] o_pass_cnt,
    output logic [CNT_W-1:0] o_fail_cnt,
    output logic             o_fail_pulse,
    output logic             o_eval_fail    // combinational: failing this cycle
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_pending;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_fail_pulse;

    logic             w_eval;
    logic             w_pass;
    logic             w_fail;

    // An obligation is only judged while the run is active; outside RUN the
    // pending bit is already clear, so inputs have no effect.
    assign w_eval = r_pending & i_active;
    assign w_pass = w_eval & i_consequent;
    assign w_fail = w_eval & ~i_consequent;

    // Pending/evaluate/count: the old obligation is judged in the same cycle
    // a new one is registered, so back-to-back antecedents are never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending    <= 1'b0;
            r_pass_cnt   <= '0;
            r_fail_cnt   <= '0;
            r_fail_pulse <= 1'b0;
        end else if (i_clear) begin
            r_pending    <= 1'b0;
            r_pass_cnt   <= '0;
            r_fail_cnt   <= '0;
            r_fail_pulse <= 1'b0;
        end else begin
            r_pending    <= i_active & ~i_flush & i_antecedent;
            r_fail_pulse <= w_fail;
            if (w_pass && (r_pass_cnt != CNT_MAX)) begin
                r_pass_cnt <= r_pass_cnt + CNT_W'(1);
            end
            if (w_fail && (r_fail_cnt != CNT_MAX)) begin
                r_fail_cnt <= r_fail_cnt + CNT_W'(1);
            end
        end
    end

    assign o_pass_cnt   = r_pass_cnt;
    assign o_fail_cnt   = r_fail_cnt;
    assign o_fail_pulse = r_fail_pulse;
    assign o_eval_fail  = w_fail;

endmodule

// File: rtl/assert_obligation_tracker.sv
// Run controller for NUM_PROPS single-step implication properties. A start
// pulse opens a run of CYC_LIMIT+1 cycles; each slot counts passes/fails,
// the first failure is latched, and the run ends in DONE or (optionally on
// the first failure) FAILED with a one-cycle stop_req.
module assert_obligation_tracker
    import assert_tb_pkg::*;
#(
    parameter  int NUM_PROPS    = DEF_NUM_PROPS,
    parameter  int CNT_W        = DEF_CNT_W,
    parameter  int CYC_LIMIT    = DEF_CYC_LIMIT,
    parameter  int STOP_ON_FAIL = 1,
    localparam int ID_W         = (NUM_PROPS > 1) ? $clog2(NUM_PROPS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [NUM_PROPS-1:0]       antecedent,
    input  logic [NUM_PROPS-1:0]       consequent,
    output logic [NUM_PROPS*CNT_W-1:0] pass_cnt,
    output logic [NUM_PROPS*CNT_W-1:0] fail_cnt,
    output logic [NUM_PROPS-1:0]       fail_pulse,
    output logic [ID_W-1:0]            first_fail_id,
    output logic [CNT_W-1:0]           first_fail_cyc,
    output logic [1:0]                 state,
    output logic                       done,
    output logic                       stop_req
);

    // The run-cycle counter must always be able to reach CYC_LIMIT, even
    // when CNT_W is narrow; the latched failure cycle saturates to CNT_W.
    localparam int               CYC_W    = max_int(CNT_W, $clog2(CYC_LIMIT + 1));
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYC_LIMIT);
    localparam logic [CYC_W-1:0] FFC_MAX  = CYC_W'({CNT_W{1'b1}});
    localparam bit               STOP_EN  = (STOP_ON_FAIL != 0);

    state_e           r_state;
    logic [CYC_W-1:0] r_cyc;
    logic             r_restart;     // auto-enter RUN after a clearing IDLE cycle
    logic             r_fail_seen;
    logic [ID_W-1:0]  r_ff_id;
    logic [CNT_W-1:0] r_ff_cyc;
    logic             r_done;
    logic             r_stop_req;

    logic [NUM_PROPS-1:0] w_eval_fail;
    logic                 w_active;
    logic                 w_any_fail;
    logic                 w_fail_stop;
    logic                 w_at_limit;
    logic                 w_leave_run;
    logic                 w_clear;
    logic [ID_W-1:0]      w_ff_id;
    logic [CNT_W-1:0]     w_ff_cyc;

    assign w_active    = (r_state == ST_RUN);
    assign w_any_fail  = |w_eval_fail;
    assign w_fail_stop = STOP_EN & w_any_fail;
    assign w_at_limit  = w_active & (r_cyc == CYC_LAST);
    assign w_leave_run = w_active & (w_fail_stop | w_at_limit);
    assign w_clear     = start & ((r_state == ST_DONE) | (r_state == ST_FAILED));

    // Lowest failing property index wins when several fail together.
    always_comb begin
        w_ff_id = '0;
        for (int i = NUM_PROPS - 1; i >= 0; i--) begin
            if (w_eval_fail[i]) begin
                w_ff_id = ID_W'(i);
            end
        end
    end

    // Failure cycle as reported, clipped to the CNT_W output range.
    always_comb begin
        w_ff_cyc = r_cyc[CNT_W-1:0];
        if (r_cyc > FFC_MAX) begin
            w_ff_cyc = '1;
        end
    end

    // Run controller: state, cycle counter, first-failure latch and the
    // registered done/stop_req outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cyc       <= '0;
            r_restart   <= 1'b0;
            r_fail_seen <= 1'b0;
            r_ff_id     <= '0;
            r_ff_cyc    <= '0;
            r_done      <= 1'b0;
            r_stop_req  <= 1'b0;
        end else begin
            r_stop_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start || r_restart) begin
                        r_state   <= ST_RUN;
                        r_cyc     <= '0;
                        r_restart <= 1'b0;
                        r_done    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_any_fail && !r_fail_seen) begin
                        r_fail_seen <= 1'b1;
                        r_ff_id     <= w_ff_id;
                        r_ff_cyc    <= w_ff_cyc;
                    end
                    if (w_fail_stop) begin
                        r_state    <= ST_FAILED;
                        r_done     <= 1'b1;
                        r_stop_req <= 1'b1;
                    end else if (w_at_limit) begin
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_stop_req <= 1'b1;
                    end else begin
                        r_cyc <= r_cyc + CYC_W'(1);
                    end
                end
                ST_FAILED, ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_IDLE;
                        r_restart   <= 1'b1;
                        r_done      <= 1'b0;
                        r_cyc       <= '0;
                        r_fail_seen <= 1'b0;
                        r_ff_id     <= '0;
                        r_ff_cyc    <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // One obligation slot per property, counters packed by property index.
    for (genvar g = 0; g < NUM_PROPS; g++) begin : g_slot
        obligation_slot #(
            .CNT_W (CNT_W)
        ) u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_clear      (w_clear),
            .i_active     (w_active),
            .i_flush      (w_leave_run),
            .i_antecedent (antecedent[g]),
            .i_consequent (consequent[g]),
            .o_pass_cnt   (pass_cnt[g*CNT_W +: CNT_W]),
            .o_fail_cnt   (fail_cnt[g*CNT_W +: CNT_W]),
            .o_fail_pulse (fail_pulse[g]),
            .o_eval_fail  (w_eval_fail[g])
        );
    end

    assign state          = r_state;
    assign done           = r_done;
    assign stop_req       = r_stop_req;
    assign first_fail_id  = r_ff_id;
    assign first_fail_cyc = r_ff_cyc;

endmodule

// File: tb/tb_assert_obligation_tracker.sv
// Bench for assert_obligation_tracker: three instances share one stimulus
// stream (default config, STOP_ON_FAIL=0, and CNT_W=3 with STOP_ON_FAIL=0);
// a rule-level model derives expected counts, end state and first failure.
module tb_assert_obligation_tracker;
    import assert_tb_pkg::*;

    localparam int NP    = 2;
    localparam int ND    = 3;
    localparam int LIMIT = 12;

    // ---------------- clock / reset ----------------
    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          start      = 1'b0;
    logic [NP-1:0] antecedent = '0;
    logic [NP-1:0] consequent = '0;

    always #5 clk = ~clk;

    // ---------------- DUT instances ----------------
    logic [31:0] pc0, fc0, pc1, fc1;
    logic [5:0]  pc2, fc2;
    logic [1:0]  fp0, fp1, fp2, st0, st1, st2;
    logic        ffid0, ffid1, ffid2;
    logic [15:0] ffc0, ffc1;
    logic [2:0]  ffc2;
    logic        dn0, dn1, dn2, sr0, sr1, sr2;

    assert_obligation_tracker u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .antecedent(antecedent), .consequent(consequent),
        .pass_cnt(pc0), .fail_cnt(fc0), .fail_pulse(fp0),
        .first_fail_id(ffid0), .first_fail_cyc(ffc0),
        .state(st0), .done(dn0), .stop_req(sr0)
    );

    assert_obligation_tracker #(.STOP_ON_FAIL(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .antecedent(antecedent), .consequent(consequent),
        .pass_cnt(pc1), .fail_cnt(fc1), .fail_pulse(fp1),
        .first_fail_id(ffid1), .first_fail_cyc(ffc1),
        .state(st1), .done(dn1), .stop_req(sr1)
    );

    assert_obligation_tracker #(.CNT_W(3), .STOP_ON_FAIL(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .antecedent(antecedent), .consequent(consequent),
        .pass_cnt(pc2), .fail_cnt(fc2), .fail_pulse(fp2),
        .first_fail_id(ffid2), .first_fail_cyc(ffc2),
        .state(st2), .done(dn2), .stop_req(sr2)
    );

    // Uniform 32-bit views of every instance's outputs.
    logic [31:0] o_pass[ND][NP];
    logic [31:0] o_fail[ND][NP];
    logic [31:0] o_fp[ND], o_st[ND], o_ffid[ND], o_ffc[ND], o_dn[ND], o_sr[ND];

    assign o_pass[0][0] = {16'd0, pc0[15:0]};
    assign o_pass[0][1] = {16'd0, pc0[31:16]};
    assign o_fail[0][0] = {16'd0, fc0[15:0]};
    assign o_fail[0][1] = {16'd0, fc0[31:16]};
    assign o_pass[1][0] = {16'd0, pc1[15:0]};
    assign o_pass[1][1] = {16'd0, pc1[31:16]};
    assign o_fail[1][0] = {16'd0, fc1[15:0]};
    assign o_fail[1][1] = {16'd0, fc1[31:16]};
    assign o_pass[2][0] = {29'd0, pc2[2:0]};
    assign o_pass[2][1] = {29'd0, pc2[5:3]};
    assign o_fail[2][0] = {29'd0, fc2[2:0]};
    assign o_fail[2][1] = {29'd0, fc2[5:3]};
    assign o_fp[0]   = {30'd0, fp0};
    assign o_fp[1]   = {30'd0, fp1};
    assign o_fp[2]   = {30'd0, fp2};
    assign o_st[0]   = {30'd0, st0};
    assign o_st[1]   = {30'd0, st1};
    assign o_st[2]   = {30'd0, st2};
    assign o_ffid[0] = {31'd0, ffid0};
    assign o_ffid[1] = {31'd0, ffid1};
    assign o_ffid[2] = {31'd0, ffid2};
    assign o_ffc[0]  = {16'd0, ffc0};
    assign o_ffc[1]  = {16'd0, ffc1};
    assign o_ffc[2]  = {29'd0, ffc2};
    assign o_dn[0]   = {31'd0, dn0};
    assign o_dn[1]   = {31'd0, dn1};
    assign o_dn[2]   = {31'd0, dn2};
    assign o_sr[0]   = {31'd0, sr0};
    assign o_sr[1]   = {31'd0, sr1};
    assign o_sr[2]   = {31'd0, sr2};

    // ---------------- scoreboard state ----------------
    int vectors;
    int miscompares;

    int cfg_stop[ND] = '{1, 0, 0};
    int cfg_w[ND]    = '{16, 16, 3};

    logic [NP-1:0] h_ant[0:15];
    logic [NP-1:0] h_cons[0:15];
    int            t_cur;

    int a_pulses[ND][NP];
    int a_stop_cnt[ND];
    int a_stop_at[ND];

    int m_pass[ND][NP];
    int m_fail[ND][NP];
    int m_pulses[ND][NP];
    int m_state[ND];
    int m_end[ND];
    int m_ffid[ND];
    int m_ffc[ND];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        for (int k = 0; k < ND; k++) begin
            check($sformatf("%s_d%0d_state", pfx, k), o_st[k], 0);
            check($sformatf("%s_d%0d_done", pfx, k), o_dn[k], 0);
            check($sformatf("%s_d%0d_stop", pfx, k), o_sr[k], 0);
            check($sformatf("%s_d%0d_fpulse", pfx, k), o_fp[k], 0);
            check($sformatf("%s_d%0d_ffid", pfx, k), o_ffid[k], 0);
            check($sformatf("%s_d%0d_ffcyc", pfx, k), o_ffc[k], 0);
            for (int i = 0; i < NP; i++) begin
                check($sformatf("%s_d%0d_pass%0d", pfx, k, i), o_pass[k][i], 0);
                check($sformatf("%s_d%0d_fail%0d", pfx, k, i), o_fail[k][i], 0);
            end
        end
    endtask

    // ---------------- reference model ----------------
    // Walks the recorded run cycle by cycle: an antecedent at cycle t is
    // judged by the consequent at t+1; the run ends at the first failure
    // (stop configs) or after cycle LIMIT; counts clip at 2^W-1.
    task automatic run_model();
        int  raw_p[NP];
        int  raw_f[NP];
        int  maxv;
        bit  seen;
        bit  ended;
        bit  fail_now;
        for (int k = 0; k < ND; k++) begin
            maxv  = (1 << cfg_w[k]) - 1;
            seen  = 1'b0;
            ended = 1'b0;
            m_state[k] = 1;
            m_end[k]   = -1;
            m_ffid[k]  = 0;
            m_ffc[k]   = 0;
            for (int i = 0; i < NP; i++) begin
                raw_p[i] = 0;
                raw_f[i] = 0;
            end
            for (int t = 0; (t <= LIMIT) && !ended; t++) begin
                fail_now = 1'b0;
                if (t > 0) begin
                    for (int i = 0; i < NP; i++) begin
                        if (h_ant[t-1][i]) begin
                            if (h_cons[t][i]) begin
                                raw_p[i]++;
                            end else begin
                                raw_f[i]++;
                                fail_now = 1'b1;
                                if (!seen) begin
                                    seen      = 1'b1;
                                    m_ffid[k] = i;
                                    m_ffc[k]  = (t > maxv) ? maxv : t;
                                end
                            end
                        end
                    end
                end
                if ((cfg_stop[k] != 0) && fail_now) begin
                    ended      = 1'b1;
                    m_state[k] = 2;
                    m_end[k]   = t;
                end else if (t == LIMIT) begin
                    ended      = 1'b1;
                    m_state[k] = 3;
                    m_end[k]   = t;
                end
            end
            for (int i = 0; i < NP; i++) begin
                m_pass[k][i]   = (raw_p[i] > maxv) ? maxv : raw_p[i];
                m_fail[k][i]   = (raw_f[i] > maxv) ? maxv : raw_f[i];
                m_pulses[k][i] = raw_f[i];
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_obs();
        for (int k = 0; k < ND; k++) begin
            a_stop_cnt[k] = 0;
            a_stop_at[k]  = -1;
            for (int i = 0; i < NP; i++) begin
                a_pulses[k][i] = 0;
            end
        end
        t_cur = 0;
    endtask

    // One run cycle: apply inputs, record them, clock, then observe strobes.
    task automatic drive_cycle(input logic [NP-1:0] a, input logic [NP-1:0] c);
        antecedent    = a;
        consequent    = c;
        h_ant[t_cur]  = a;
        h_cons[t_cur] = c;
        @(posedge clk);
        #1;
        for (int k = 0; k < ND; k++) begin
            if (o_sr[k][0]) begin
                a_stop_cnt[k]++;
                a_stop_at[k] = t_cur;
            end
            for (int i = 0; i < NP; i++) begin
                if (o_fp[k][i]) begin
                    a_pulses[k][i]++;
                end
            end
        end
        t_cur++;
    endtask

    task automatic begin_from_idle();
        antecedent = '0;
        consequent = '0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        clear_obs();
    endtask

    // From DONE/FAILED: start clears everything into IDLE, RUN follows.
    task automatic restart(input string name);
        antecedent = '0;
        consequent = '0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_all_zero({name, "_idle"});
        @(posedge clk);
        #1;
        clear_obs();
    endtask

    task automatic fill_run();
        while (t_cur <= LIMIT) begin
            drive_cycle('0, '0);
        end
    endtask

    task automatic finish_run(input string name);
        run_model();
        for (int k = 0; k < ND; k++) begin
            for (int i = 0; i < NP; i++) begin
                check($sformatf("%s_d%0d_pass%0d", name, k, i), o_pass[k][i], m_pass[k][i]);
                check($sformatf("%s_d%0d_fail%0d", name, k, i), o_fail[k][i], m_fail[k][i]);
                check($sformatf("%s_d%0d_pulses%0d", name, k, i), a_pulses[k][i], m_pulses[k][i]);
            end
            check($sformatf("%s_d%0d_state", name, k), o_st[k], m_state[k]);
            check($sformatf("%s_d%0d_done", name, k), o_dn[k], (m_state[k] >= 2) ? 1 : 0);
            check($sformatf("%s_d%0d_nstop", name, k), a_stop_cnt[k], (m_end[k] >= 0) ? 1 : 0);
            if (m_end[k] >= 0) begin
                check($sformatf("%s_d%0d_stop_at", name, k), a_stop_at[k], m_end[k]);
            end
            check($sformatf("%s_d%0d_ffid", name, k), o_ffid[k], m_ffid[k]);
            check($sformatf("%s_d%0d_ffcyc", name, k), o_ffc[k], m_ffc[k]);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [NP-1:0] ra;
        logic [NP-1:0] rc;
        int            nsr;
        vectors     = 0;
        miscompares = 0;
        clear_obs();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("post_rst");

        // Single pass on property 0; a start pulse mid-run is ignored.
        begin_from_idle();
        drive_cycle(2'b01, 2'b00);
        drive_cycle(2'b00, 2'b01);
        check("pass_one_cnt", o_pass[0][0], 1);
        check("pass_one_fail", o_fail[0][0], 0);
        check("pass_one_fp", o_fp[0], 0);
        start = 1'b1;
        drive_cycle(2'b00, 2'b00);
        start = 1'b0;
        check("start_in_run", o_st[0], 1);
        fill_run();
        finish_run("t_pass");

        // Property 1 fails at cycle 4.
        restart("t_fail");
        repeat (3) drive_cycle(2'b00, 2'b00);
        drive_cycle(2'b10, 2'b11);
        drive_cycle(2'b00, 2'b00);
        check("fail_fp", o_fp[0], 2);
        check("fail_state", o_st[0], 2);
        check("fail_stop", o_sr[0], 1);
        check("fail_done", o_dn[0], 1);
        check("fail_ffid", o_ffid[0], 1);
        check("fail_ffcyc", o_ffc[0], 4);
        drive_cycle(2'b00, 2'b00);
        check("fail_fp_clr", o_fp[0], 0);
        check("fail_stop_clr", o_sr[0], 0);
        check("fail_state_hold", o_st[0], 2);
        fill_run();
        finish_run("t_fail");

        // Overlapping attempts: antecedent held five cycles.
        restart("t_ovl");
        for (int t = 0; t < 5; t++) begin
            drive_cycle(2'b01, 2'b01);
        end
        drive_cycle(2'b00, 2'b01);
        check("ovl_pass5", o_pass[0][0], 5);
        fill_run();
        finish_run("t_ovl");

        // Both properties fail together at cycle 3.
        restart("t_both");
        repeat (2) drive_cycle(2'b00, 2'b00);
        drive_cycle(2'b11, 2'b11);
        drive_cycle(2'b00, 2'b00);
        check("both_ffid", o_ffid[0], 0);
        check("both_ffcyc", o_ffc[0], 3);
        check("both_fp", o_fp[0], 3);
        fill_run();
        finish_run("t_both");

        // Toggle pattern: non-stopping configs run to DONE.
        restart("t_tog");
        for (int t = 0; t <= LIMIT; t++) begin
            drive_cycle(2'b11, ((t % 2) == 0) ? 2'b01 : 2'b10);
        end
        check("tog_d1_state", o_st[1], 3);
        finish_run("t_tog");

        // Randomized runs, mostly passing so some stopping runs reach DONE.
        for (int r = 0; r < 6; r++) begin
            restart($sformatf("t_rnd%0d", r));
            for (int t = 0; t <= LIMIT; t++) begin
                ra    = NP'($urandom_range(0, 3));
                rc[0] = ($urandom_range(0, 7) != 0);
                rc[1] = ($urandom_range(0, 7) != 0);
                drive_cycle(ra, rc);
            end
            finish_run($sformatf("t_rnd%0d", r));
        end

        // Reset in the middle of a run (cycle 6).
        restart("t_mrst");
        for (int t = 0; t < 6; t++) begin
            drive_cycle(NP'($urandom_range(0, 3)), 2'b11);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mrst");
        nsr = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            nsr += int'(sr0) + int'(sr1) + int'(sr2);
        end
        check("mrst_nostop", nsr, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_idle", o_st[0], 0);

        // Nine passes: the 3-bit instance saturates at 7.
        begin_from_idle();
        for (int t = 0; t < 9; t++) begin
            drive_cycle(2'b01, 2'b11);
        end
        drive_cycle(2'b00, 2'b11);
        check("sat_w3_pass", o_pass[2][0], 7);
        check("sat_w16_pass", o_pass[1][0], 9);
        fill_run();
        finish_run("t_sat");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
